request_encoder: RTL and testbench
==================================

Name: request_encoder

Overview:
- Sequential 2^N-to-N encoder; the inverse of the register-file write-select decoder path.
- Collects one-hot or multi-hot request lines into a pending set, then emits one binary index at a time with a valid/ready handshake.
- Clears each pending bit as its index is accepted.
- Sits between request sources (e.g. per-register write requests) and a consumer that accepts one encoded select per cycle.

Parameters:
- SEL_W, 2, index width in bits.
- NUM_REQ, 2**SEL_W, number of request lines (derived; do not override independently).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- ena  input  1  request capture enable; when low, req_in is ignored.
- req_in  input  NUM_REQ  request lines, sampled each clk when ena=1.
- idx_ready  input  1  consumer accepts idx this cycle.
- idx  output  SEL_W  encoded index of the presented request.
- idx_valid  output  1  idx is valid.
- pending  output  NUM_REQ  current pending-set register.
- coalesced  output  1  registered one-cycle pulse: a request hit an already-pending bit.

Behaviour:
- Reset (async, reset_n=0): pending=0, idx=0, idx_valid=0, coalesced=0, FSM=IDLE. Takes effect immediately, with no clock edge, including mid-handshake. Outputs hold reset values while reset_n=0.
- accept = idx_valid & idx_ready.
- clr_mask = accept ? onehot(idx) : 0.
- pending_next = (pending & ~clr_mask) | (ena ? req_in : 0).
- Set wins over clear: a bit re-requested in its accept cycle stays pending.
- coalesced_next = ena & |(req_in & pending & ~clr_mask). Asserts for exactly the cycle after the collision.
- pick(v) = index of lowest set bit of v. Fixed priority, bit 0 highest.
- FSM, IDLE (idx_valid=0):
  - if pending != 0: load idx = pick(pending), go to PRESENT.
  - otherwise stay in IDLE.
- FSM, PRESENT (idx_valid=1):
  - idx and idx_valid are held stable while idx_ready=0, even if a higher-priority request arrives.
  - On accept, let rem = pending & ~clr_mask.
  - if rem != 0: idx = pick(rem), stay in PRESENT. Gives back-to-back throughput of one index per cycle.
  - otherwise go to IDLE.
  - Requests captured in the accept cycle are not considered until the following cycle.
- Latency: req_in sampled at edge E, pending set after E, idx_valid=1 after E+1. Two edges from request to valid.
- idx_ready while idx_valid=0 has no effect.
- ena=0: no new captures; draining of existing pending bits continues normally.
- Duplicate requests to a bit that is already pending are merged (single presentation) and signalled via coalesced.

Optional Feature:
- Macro: REQ_ENC_RR_PRIORITY_EN.
- Defined: round-robin priority. A last-grant pointer (SEL_W bits, reset value NUM_REQ-1) updates to idx on every accept. pick(v) returns the first set bit at or after (last+1) mod NUM_REQ, wrapping around. A continuously asserted request therefore cannot starve the others.
- Undefined: fixed lowest-index priority as above; no pointer register is instantiated.

Test Plan (SEL_W=2):
- Reset, ena=1, req_in=4'b0100 for one cycle, idx_ready=1 -> idx_valid=1, idx=2 two edges later for exactly one cycle; pending returns to 4'b0000; coalesced stays 0.
- req_in=4'b1011 for one cycle, idx_ready=1 -> idx sequence 0, 1, 3 on consecutive cycles, then idx_valid=0 and pending=0.
- Backpressure, all with idx_ready=0:
  - pending=4'b0100 presents idx=2.
  - Then req_in=4'b0001 arrives -> idx holds 2 with pending=4'b0101.
  - Raise idx_ready -> next cycle idx=0, then idx_valid=0.
- ena=0, req_in=4'hF for 3 cycles -> pending=0, idx_valid=0, coalesced=0 throughout.
- Collision:
  - idx=1 accepted while req_in=4'b0010 in the same cycle -> pending bit 1 remains set, idx=1 is presented again, coalesced=0.
  - A separate req_in=4'b0010 while bit 1 is pending and not being accepted -> coalesced=1 for one cycle.
- Async reset: drop reset_n mid-PRESENT between clock edges -> idx_valid=0, pending=0 immediately. With REQ_ENC_RR_PRIORITY_EN and req_in=4'b0011 held continuously, the grants alternate 0, 1, 0, 1.

Source files
------------

// File: rtl/request_encoder_if.sv
// Request/index bundle for request_encoder: request capture lines in,
// one encoded index out per accepted handshake.
interface request_encoder_if #(
  parameter int SEL_W = 2
);
  localparam int NUM_REQ = 2 ** SEL_W;

  // Handshake: idx transfers on a cycle where idx_valid && idx_ready at the
  // rising clk edge. While idx_valid is high and idx_ready low, idx and
  // idx_valid stay stable. idx_ready while idx_valid is low is ignored.
  logic               ena;
  logic [NUM_REQ-1:0] req_in;
  logic               idx_ready;
  logic [SEL_W-1:0]   idx;
  logic               idx_valid;
  logic [NUM_REQ-1:0] pending;
  logic               coalesced;
  logic               state_dbg;

  modport master (
    output ena, req_in, idx_ready,
    input  idx, idx_valid, pending, coalesced, state_dbg
  );

  modport slave (
    input  ena, req_in, idx_ready,
    output idx, idx_valid, pending, coalesced, state_dbg
  );
endinterface

// File: rtl/request_encoder.sv
// Sequential 2^SEL_W-to-SEL_W request encoder: collects request lines into a
// pending set and presents one index per handshake. REQ_ENC_RR_PRIORITY_EN selects round-robin pick.
module request_encoder #(
  parameter int SEL_W = 2
) (
  input logic              clk,
  input logic              reset_n,
  request_encoder_if.slave bus
);
  localparam int NUM_REQ = 2 ** SEL_W;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [SEL_W-1:0]   idx_r;
  logic [SEL_W-1:0]   idx_next;
  logic [NUM_REQ-1:0] pend_r;
  logic [NUM_REQ-1:0] pend_next;
  logic [NUM_REQ-1:0] clr_mask;
  logic [NUM_REQ-1:0] rem;
  logic [NUM_REQ-1:0] cap;
  logic               coal_r;
  logic               coal_next;
  logic               accept;
  logic [SEL_W-1:0]   start;

  // First set bit scanning upward from start, wrapping around.
  function automatic logic [SEL_W-1:0] pick(input logic [NUM_REQ-1:0] v,
                                            input logic [SEL_W-1:0]   from);
    logic [SEL_W-1:0] j;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = from + SEL_W'(i);
      if (!found && v[j]) begin
        pick  = j;
        found = 1'b1;
      end
    end
  endfunction

  assign accept    = (state == PRESENT) && bus.idx_ready;
  assign clr_mask  = accept ? (NUM_REQ'(1) << idx_r) : '0;
  assign rem       = pend_r & ~clr_mask;
  assign cap       = bus.ena ? bus.req_in : '0;
  // Set wins over clear, so a bit re-requested while being accepted survives.
  assign pend_next = rem | cap;
  assign coal_next = |(cap & rem);

`ifdef REQ_ENC_RR_PRIORITY_EN
  logic [SEL_W-1:0] last_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_r <= SEL_W'(NUM_REQ - 1);
    end else if (accept) begin
      last_r <= idx_r;
    end
  end

  // On an accept the grant just made is the new "last" for the follow-on pick.
  assign start = (accept ? idx_r : last_r) + SEL_W'(1);
`else
  assign start = '0;
`endif

  always_comb begin
    state_next = state;
    idx_next   = idx_r;
    case (state)
      IDLE: begin
        if (|pend_r) begin
          idx_next   = pick(pend_r, start);
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (accept) begin
          if (|rem) begin
            idx_next = pick(rem, start);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx_r  <= '0;
      pend_r <= '0;
      coal_r <= 1'b0;
    end else begin
      state  <= state_next;
      idx_r  <= idx_next;
      pend_r <= pend_next;
      coal_r <= coal_next;
    end
  end

  assign bus.idx       = idx_r;
  assign bus.idx_valid = (state == PRESENT);
  assign bus.pending   = pend_r;
  assign bus.coalesced = coal_r;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_request_encoder.sv
// Bench for request_encoder (SEL_W=2): vector table, hand-written async-reset
// and round-robin sequences, and randomized traffic against a reference model.
module tb_request_encoder;
  localparam int SEL_W = 2;
  localparam int NUM   = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  request_encoder_if #(.SEL_W(SEL_W)) bus ();

  request_encoder #(.SEL_W(SEL_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit       rst;
    bit       ena;
    bit [3:0] req;
    bit       rdy;
    bit       v;
    bit [1:0] idx;
    bit [3:0] pend;
    bit       coal;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: pending set as a plain bit array plus the
  // currently presented grant and the most recent accepted grant.
  bit m_pend[NUM];
  bit m_valid;
  int m_idx;
  int m_last;
  bit m_coal;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ena, input bit [3:0] req, input bit rdy);
    bus.ena       = ena;
    bus.req_in    = req;
    bus.idx_ready = rdy;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) m_pend[i] = 1'b0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_last  = NUM - 1;
    m_coal  = 1'b0;
  endtask

  function automatic int any_set(input bit s[NUM]);
    int n = 0;
    for (int i = 0; i < NUM; i++) n += s[i];
    return n;
  endfunction

  // Next grant: first pending bit scanning from the priority origin.
  function automatic int grant(input bit s[NUM], input int origin);
    for (int k = 0; k < NUM; k++) begin
      if (s[(origin + k) % NUM]) return (origin + k) % NUM;
    end
    return 0;
  endfunction

  function automatic int origin_now();
`ifdef REQ_ENC_RR_PRIORITY_EN
    return (m_last + 1) % NUM;
`else
    return 0;
`endif
  endfunction

  task automatic model_step(input bit ena, input bit [3:0] req, input bit rdy);
    bit was_pending[NUM];
    bit left[NUM];
    bit taken;
    taken  = m_valid && rdy;
    m_coal = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      was_pending[i] = m_pend[i];
      left[i]        = m_pend[i];
    end
    if (taken) begin
      left[m_idx] = 1'b0;
      m_last      = m_idx;
    end
    for (int i = 0; i < NUM; i++) begin
      if (ena && req[i] && left[i]) m_coal = 1'b1;
      m_pend[i] = left[i] || (ena && req[i]);
    end
    if (m_valid) begin
      if (taken) begin
        if (any_set(left) > 0) m_idx = grant(left, origin_now());
        else m_valid = 1'b0;
      end
    end else if (any_set(was_pending) > 0) begin
      m_valid = 1'b1;
      m_idx   = grant(was_pending, origin_now());
    end
  endtask

  function automatic bit [3:0] model_pend_vec();
    bit [3:0] v;
    for (int i = 0; i < NUM; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic reset_dut();
    drive(1'b0, 4'h0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("reset_valid", 32'(bus.idx_valid), 32'd0);
    chk("reset_pending", 32'(bus.pending), 32'd0);
    chk("reset_idx", 32'(bus.idx), 32'd0);
    chk("reset_coalesced", 32'(bus.coalesced), 32'd0);
    tick();
    reset_n = 1'b1;
    model_reset();
  endtask

  function automatic void add(input bit rst, input bit ena, input bit [3:0] req, input bit rdy,
                              input bit v, input bit [1:0] idx, input bit [3:0] pend, input bit coal);
    vec_t e;
    e.rst = rst; e.ena = ena; e.req = req; e.rdy = rdy;
    e.v = v; e.idx = idx; e.pend = pend; e.coal = coal;
    vecs.push_back(e);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   rst ena req     rdy  v  idx  pend    coal
    // single request presented once
    add(1, 1, 4'b0100, 1,  0, 0, 4'b0100, 0);
    add(0, 1, 4'b0000, 1,  1, 2, 4'b0100, 0);
    add(0, 1, 4'b0000, 1,  0, 0, 4'b0000, 0);
    add(0, 1, 4'b0000, 1,  0, 0, 4'b0000, 0);
    // multi-hot drains back to back
    add(1, 1, 4'b1011, 1,  0, 0, 4'b1011, 0);
    add(0, 1, 4'b0000, 1,  1, 0, 4'b1011, 0);
    add(0, 1, 4'b0000, 1,  1, 1, 4'b1010, 0);
    add(0, 1, 4'b0000, 1,  1, 3, 4'b1000, 0);
    add(0, 1, 4'b0000, 1,  0, 0, 4'b0000, 0);
    // backpressure holds idx even when a higher priority bit arrives
    add(1, 1, 4'b0100, 0,  0, 0, 4'b0100, 0);
    add(0, 1, 4'b0000, 0,  1, 2, 4'b0100, 0);
    add(0, 1, 4'b0001, 0,  1, 2, 4'b0101, 0);
    add(0, 1, 4'b0000, 0,  1, 2, 4'b0101, 0);
    add(0, 1, 4'b0000, 1,  1, 0, 4'b0001, 0);
    add(0, 1, 4'b0000, 1,  0, 0, 4'b0000, 0);
    // capture disabled
    add(1, 0, 4'b1111, 1,  0, 0, 4'b0000, 0);
    add(0, 0, 4'b1111, 1,  0, 0, 4'b0000, 0);
    add(0, 0, 4'b1111, 1,  0, 0, 4'b0000, 0);
    // re-request during accept, then a true collision
    add(1, 1, 4'b0010, 0,  0, 0, 4'b0010, 0);
    add(0, 1, 4'b0000, 0,  1, 1, 4'b0010, 0);
    add(0, 1, 4'b0010, 1,  0, 0, 4'b0010, 0);
    add(0, 1, 4'b0000, 0,  1, 1, 4'b0010, 0);
    add(0, 1, 4'b0010, 0,  1, 1, 4'b0010, 1);
    add(0, 1, 4'b0000, 0,  1, 1, 4'b0010, 0);
    add(0, 1, 4'b0000, 1,  0, 0, 4'b0000, 0);

    drive(1'b0, 4'h0, 1'b0);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) reset_dut();
      drive(vecs[i].ena, vecs[i].req, vecs[i].rdy);
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(bus.idx_valid), 32'(vecs[i].v));
      chk($sformatf("vec%0d_state", i), 32'(bus.state_dbg), 32'(vecs[i].v));
      chk($sformatf("vec%0d_pending", i), 32'(bus.pending), 32'(vecs[i].pend));
      chk($sformatf("vec%0d_coalesced", i), 32'(bus.coalesced), 32'(vecs[i].coal));
      if (vecs[i].v) chk($sformatf("vec%0d_idx", i), 32'(bus.idx), 32'(vecs[i].idx));
    end

    // asynchronous reset between edges while presenting
    reset_dut();
    drive(1'b1, 4'b0100, 1'b0);
    tick();
    drive(1'b1, 4'b0000, 1'b0);
    tick();
    chk("async_pre_valid", 32'(bus.idx_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(bus.idx_valid), 32'd0);
    chk("async_pending", 32'(bus.pending), 32'd0);
    chk("async_idx", 32'(bus.idx), 32'd0);
    drive(1'b1, 4'b1111, 1'b1);
    tick();
    chk("async_hold_valid", 32'(bus.idx_valid), 32'd0);
    chk("async_hold_pending", 32'(bus.pending), 32'd0);
    chk("async_hold_coalesced", 32'(bus.coalesced), 32'd0);
    reset_n = 1'b1;
    model_reset();

    // two requests held continuously: grants alternate
    reset_dut();
    drive(1'b1, 4'b0011, 1'b1);
    tick();
    chk("alt_pending", 32'(bus.pending), 32'h3);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("alt%0d_valid", k), 32'(bus.idx_valid), 32'd1);
      chk($sformatf("alt%0d_idx", k), 32'(bus.idx), 32'(k % 2));
    end

    // randomized traffic against the reference model
    reset_dut();
    for (int c = 0; c < 1500; c++) begin
      bit       r_ena;
      bit [3:0] r_req;
      bit       r_rdy;
      r_ena = ($urandom_range(0, 3) != 0);
      r_req = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      r_rdy = ($urandom_range(0, 2) != 0);
      drive(r_ena, r_req, r_rdy);
      model_step(r_ena, r_req, r_rdy);
      tick();
      chk($sformatf("rnd%0d_valid", c), 32'(bus.idx_valid), 32'(m_valid));
      chk($sformatf("rnd%0d_pending", c), 32'(bus.pending), 32'(model_pend_vec()));
      chk($sformatf("rnd%0d_coalesced", c), 32'(bus.coalesced), 32'(m_coal));
      if (m_valid) chk($sformatf("rnd%0d_idx", c), 32'(bus.idx), 32'(m_idx));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
